control_sequencer: RTL
======================

// Module: control_sequencer
// PURPOSE
//  Hardwired control unit for the Mini-SRC bus datapath. Walks the T0..T6 micro-steps of fetch and
//  execute and drives the datapath strobes (register in/out, Read, Zin, IncPC, ALU_Control) each cycle.
//  Covers ALU R-type, immediate, unary, mul/div, nop and halt. Register selects are emitted as
//  Gra/Grb/Grc plus Rin/Rout for a downstream select-and-encode stage.
// PARAMETERS
//  OPW          5   opcode width, IR[31:27]
//  MEM_TIMEOUT  16  max cycles T1 waits for mem_ready before faulting (>=1)
//  CNTW         16  width of retired-instruction counter
// PORTS
//  clock        in   1     system clock, all state on rising edge
//  clear        in   1     synchronous active-low reset (0 = reset on next rising edge)
//  run          in   1     level; 1 = sequencer may start a new fetch from IDLE
//  ir           in   32    IR register contents (opcode IR[31:27])
//  mem_ready    in   1     memory data valid on Mdatain during T1
//  PCout,MARin,IncPC,Zin,Zlowout,Zhighout,PCin,Read,MDRin,MDRout,IRin,Yin,Cout,HIin,LOin  out 1 each  datapath strobes
//  Gra,Grb,Grc,Rin,Rout  out 1 each  GPR field select / direction for select-and-encode
//  alu_control  out  OPW   ALU op code to ALU
//  busy         out  1     1 from T0 through last execute step
//  halted       out  1     1 in HALT state
//  fault        out  1     sticky: memory timeout (or illegal opcode, see CONFIGURATION)
//  inst_count   out  CNTW  retired instructions, wraps 2^CNTW-1 -> 0
// BEHAVIOUR
//  - Reset (clear=0 at edge): state=IDLE, all strobes 0, alu_control=0, busy/halted/fault=0, inst_count=0.
//    Reset wins over every other condition, including mid-instruction.
//  - All outputs are Moore (decoded from registered state + ir); at most one *out strobe high per cycle.
//  - IDLE: run=1 -> T0 next cycle; else stay.
//  - T0: PCout,MARin,IncPC,Zin -> T1.
//  - T1: Zlowout,PCin,Read,MDRin held while waiting; mem_ready=1 -> T2. Wait counter resets on entry;
//    MEM_TIMEOUT cycles without mem_ready -> fault=1, state=HALT. PCin/MDRin repeat harmlessly.
//  - T2: MDRout,IRin -> T3 (IR valid from T3 on).
//  - T3 by class: R-type/imm/mul/div: Grb,Rout,Yin -> T4. unary (neg,not): Grb,Rout,Zin,
//    alu_control=op -> T5. nop -> retire. halt -> HALT.
//  - T4: R-type/mul/div: Grc,Rout,Zin,alu_control=op. imm: Cout,Zin,alu_control=op. -> T5.
//  - T5: R/imm/unary: Zlowout,Gra,Rin -> retire. mul/div: Zlowout,LOin -> T6.
//  - T6: Zhighout,HIin -> retire.
//  - retire: inst_count+=1; next state T0 if run=1 else IDLE (run sampled at retire step only).
//  - HALT: absorbing, halted=1, exit only via reset.
//  - busy=1 in T0..T6; 0 in IDLE and HALT.
//  - Opcodes: add 00011 sub 00100 and 00101 or 00110 ror 00111 rol 01000 shr 01001 shra 01010
//    shl 01011 addi 01100 andi 01101 ori 01110 div 01111 mul 10000 neg 10001 not 10010
//    nop 11010 halt 11011; alu_control = opcode in T3(unary)/T4, else 0.
//  - Other opcodes (ld/st/branch etc.) are illegal for this block.
// CONFIGURATION
//  SEQ_ILLEGAL_TRAP_EN defined: illegal opcode at T3 -> fault=1, HALT.
//  Not defined: illegal opcode treated as nop (retire at T3, counted), fault only from timeout.
// STRUCTURE
//  mini_src_pkg: opcode localparams, class codes (RTYPE,IMM,UNARY,MULDIV,NOP,HALT,ILLEGAL),
//  state encoding (IDLE,T0..T6,HALT), OPW. One sub-module: seq_decode (combinational
//  opcode -> class); FSM, wait counter and inst_count stay in control_sequencer.
// TESTING
//  1 add r3,r1,r2 (ir=0x19880000), run=1, mem_ready=1 -> T0..T5 in 6 cycles, T4 alu_control=00011, inst_count=1.
//  2 mul, mem_ready delayed 3 cycles -> T1 held 4 cycles, T6 asserts Zhighout+HIin, total 10 cycles.
//  3 mem_ready never high, MEM_TIMEOUT=16 -> HALT after 16 T1 cycles, fault=1, halted=1, busy=0.
//  4 halt opcode 11011 -> HALT at cycle after T3; inst_count unchanged; run toggling has no effect.
//  5 clear=0 during T4 -> next edge IDLE, all strobes 0, inst_count=0; clear=1,run=1 restarts at T0.
//  6 opcode 11111 -> with SEQ_ILLEGAL_TRAP_EN fault=1 HALT; without, retire and inst_count+1.

Source files
------------

// File: rtl/mini_src_pkg.sv
// rtl/mini_src_pkg.sv - Mini-SRC control sequencer opcodes, instruction classes and state encoding
package mini_src_pkg;

  localparam int OPW = 5;

  localparam logic [4:0] OP_ADD  = 5'b00011;
  localparam logic [4:0] OP_SUB  = 5'b00100;
  localparam logic [4:0] OP_AND  = 5'b00101;
  localparam logic [4:0] OP_OR   = 5'b00110;
  localparam logic [4:0] OP_ROR  = 5'b00111;
  localparam logic [4:0] OP_ROL  = 5'b01000;
  localparam logic [4:0] OP_SHR  = 5'b01001;
  localparam logic [4:0] OP_SHRA = 5'b01010;
  localparam logic [4:0] OP_SHL  = 5'b01011;
  localparam logic [4:0] OP_ADDI = 5'b01100;
  localparam logic [4:0] OP_ANDI = 5'b01101;
  localparam logic [4:0] OP_ORI  = 5'b01110;
  localparam logic [4:0] OP_DIV  = 5'b01111;
  localparam logic [4:0] OP_MUL  = 5'b10000;
  localparam logic [4:0] OP_NEG  = 5'b10001;
  localparam logic [4:0] OP_NOT  = 5'b10010;
  localparam logic [4:0] OP_NOP  = 5'b11010;
  localparam logic [4:0] OP_HALT = 5'b11011;

  typedef enum logic [2:0] {
    CLS_RTYPE,
    CLS_IMM,
    CLS_UNARY,
    CLS_MULDIV,
    CLS_NOP,
    CLS_HALT,
    CLS_ILLEGAL
  } cls_e;

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_T0,
    ST_T1,
    ST_T2,
    ST_T3,
    ST_T4,
    ST_T5,
    ST_T6,
    ST_HALT
  } state_e;

endpackage

// File: rtl/seq_decode.sv
// rtl/seq_decode.sv - combinational opcode to instruction-class decode
module seq_decode
  import mini_src_pkg::*;
(
  input  logic [OPW-1:0] opcode_i,
  output logic [2:0]     cls_o
);

  always_comb begin
    cls_o = CLS_ILLEGAL;
    unique case (opcode_i)
      OP_ADD, OP_SUB, OP_AND, OP_OR, OP_ROR, OP_ROL,
      OP_SHR, OP_SHRA, OP_SHL:        cls_o = CLS_RTYPE;
      OP_ADDI, OP_ANDI, OP_ORI:       cls_o = CLS_IMM;
      OP_NEG, OP_NOT:                 cls_o = CLS_UNARY;
      OP_MUL, OP_DIV:                 cls_o = CLS_MULDIV;
      OP_NOP:                         cls_o = CLS_NOP;
      OP_HALT:                        cls_o = CLS_HALT;
      default:                        cls_o = CLS_ILLEGAL;
    endcase
  end

endmodule

// File: rtl/control_sequencer.sv
// rtl/control_sequencer.sv - Mini-SRC hardwired T0..T6 control sequencer
// Define SEQ_ILLEGAL_TRAP_EN to fault and halt on illegal opcodes instead of retiring them as nop.
module control_sequencer
  import mini_src_pkg::*;
#(
  parameter int OPW         = 5,
  parameter int MEM_TIMEOUT = 16,
  parameter int CNTW        = 16
) (
  input  logic            clock,
  input  logic            clear,
  input  logic            run,
  input  logic [31:0]     ir,
  input  logic            mem_ready,
  output logic            PCout,
  output logic            MARin,
  output logic            IncPC,
  output logic            Zin,
  output logic            Zlowout,
  output logic            Zhighout,
  output logic            PCin,
  output logic            Read,
  output logic            MDRin,
  output logic            MDRout,
  output logic            IRin,
  output logic            Yin,
  output logic            Cout,
  output logic            HIin,
  output logic            LOin,
  output logic            Gra,
  output logic            Grb,
  output logic            Grc,
  output logic            Rin,
  output logic            Rout,
  output logic [OPW-1:0]  alu_control,
  output logic            busy,
  output logic            halted,
  output logic            fault,
  output logic [CNTW-1:0] inst_count
);

`ifdef SEQ_ILLEGAL_TRAP_EN
  localparam bit TRAP_ILLEGAL = 1'b1;
`else
  localparam bit TRAP_ILLEGAL = 1'b0;
`endif

  localparam int WW = (MEM_TIMEOUT > 1) ? $clog2(MEM_TIMEOUT) : 1;
  localparam logic [WW-1:0] WAIT_LAST = WW'(MEM_TIMEOUT - 1);

  state_e          state_q;
  logic [WW-1:0]   wait_q;
  logic [CNTW-1:0] count_q;
  logic            fault_q;

  logic [OPW-1:0]  opcode;
  logic [2:0]      cls_raw;
  cls_e            cls;
  logic            retire;
  logic            unused_ir;

  assign opcode    = ir[31 -: OPW];
  assign unused_ir = ^ir[31-OPW:0];

  seq_decode u_decode (
    .opcode_i (opcode),
    .cls_o    (cls_raw)
  );

  assign cls = cls_e'(cls_raw);

  // Last step of every instruction that completes normally; run is only sampled here.
  always_comb begin
    retire = 1'b0;
    unique case (state_q)
      ST_T3:   retire = (cls == CLS_NOP) || ((cls == CLS_ILLEGAL) && !TRAP_ILLEGAL);
      ST_T5:   retire = (cls != CLS_MULDIV);
      ST_T6:   retire = 1'b1;
      default: retire = 1'b0;
    endcase
  end

  always_ff @(posedge clock) begin
    if (!clear) begin
      state_q <= ST_IDLE;
      wait_q  <= '0;
      count_q <= '0;
      fault_q <= 1'b0;
    end else if (retire) begin
      count_q <= count_q + 1'b1;
      state_q <= run ? ST_T0 : ST_IDLE;
    end else begin
      unique case (state_q)
        ST_IDLE: if (run) state_q <= ST_T0;
        ST_T0: begin
          wait_q  <= '0;
          state_q <= ST_T1;
        end
        ST_T1: begin
          if (mem_ready) begin
            state_q <= ST_T2;
          end else if (wait_q == WAIT_LAST) begin
            fault_q <= 1'b1;
            state_q <= ST_HALT;
          end else begin
            wait_q <= wait_q + 1'b1;
          end
        end
        ST_T2: state_q <= ST_T3;
        ST_T3: begin
          unique case (cls)
            CLS_UNARY: state_q <= ST_T5;
            CLS_HALT:  state_q <= ST_HALT;
            CLS_ILLEGAL: begin
              fault_q <= 1'b1;
              state_q <= ST_HALT;
            end
            default:   state_q <= ST_T4;
          endcase
        end
        ST_T4:   state_q <= ST_T5;
        ST_T5:   state_q <= ST_T6;
        default: state_q <= state_q;
      endcase
    end
  end

  always_comb begin
    PCout       = 1'b0;
    MARin       = 1'b0;
    IncPC       = 1'b0;
    Zin         = 1'b0;
    Zlowout     = 1'b0;
    Zhighout    = 1'b0;
    PCin        = 1'b0;
    Read        = 1'b0;
    MDRin       = 1'b0;
    MDRout      = 1'b0;
    IRin        = 1'b0;
    Yin         = 1'b0;
    Cout        = 1'b0;
    HIin        = 1'b0;
    LOin        = 1'b0;
    Gra         = 1'b0;
    Grb         = 1'b0;
    Grc         = 1'b0;
    Rin         = 1'b0;
    Rout        = 1'b0;
    alu_control = '0;
    unique case (state_q)
      ST_T0: begin
        PCout = 1'b1;
        MARin = 1'b1;
        IncPC = 1'b1;
        Zin   = 1'b1;
      end
      ST_T1: begin
        Zlowout = 1'b1;
        PCin    = 1'b1;
        Read    = 1'b1;
        MDRin   = 1'b1;
      end
      ST_T2: begin
        MDRout = 1'b1;
        IRin   = 1'b1;
      end
      ST_T3: begin
        if (cls == CLS_RTYPE || cls == CLS_IMM || cls == CLS_MULDIV) begin
          Grb  = 1'b1;
          Rout = 1'b1;
          Yin  = 1'b1;
        end else if (cls == CLS_UNARY) begin
          Grb         = 1'b1;
          Rout        = 1'b1;
          Zin         = 1'b1;
          alu_control = opcode;
        end
      end
      ST_T4: begin
        Zin         = 1'b1;
        alu_control = opcode;
        if (cls == CLS_IMM) begin
          Cout = 1'b1;
        end else begin
          Grc  = 1'b1;
          Rout = 1'b1;
        end
      end
      ST_T5: begin
        Zlowout = 1'b1;
        if (cls == CLS_MULDIV) begin
          LOin = 1'b1;
        end else begin
          Gra = 1'b1;
          Rin = 1'b1;
        end
      end
      ST_T6: begin
        Zhighout = 1'b1;
        HIin     = 1'b1;
      end
      default: ;
    endcase
  end

  assign busy       = (state_q != ST_IDLE) && (state_q != ST_HALT);
  assign halted     = (state_q == ST_HALT);
  assign fault      = fault_q;
  assign inst_count = count_q;

endmodule
